// File: rtl/squid_rs_encoder.sv
// Systematic Reed-Solomon encoder over GF(16), g(x) = x^2 + 3x + 2, valid/ready in and out.
// Optional output error injection (inj_en/inj_mask ports) is enabled by defining SQUID_ENC_ERR_INJ_EN.
module squid_rs_encoder #(
  parameter int DATA_SYMS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [3:0] m_data,
  output logic       m_is_parity,
  output logic       m_last
`ifdef SQUID_ENC_ERR_INJ_EN
  ,
  input  logic       inj_en,
  input  logic [3:0] inj_mask
`endif
);

  localparam int CW = (DATA_SYMS > 1) ? $clog2(DATA_SYMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SYMS - 1);

  typedef enum logic [1:0] {ST_DATA, ST_PAR1, ST_PAR0} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    p1;
  logic [3:0]    p0;
  logic [3:0]    fb;
  logic [3:0]    inj_xor;
  logic          load;

  // Carry-less 4x4 multiply followed by reduction modulo x^4 + x + 1.
  function automatic logic [3:0] gfmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] prod;
    prod = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) prod = prod ^ ({3'b000, a} << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (prod[i]) prod = prod ^ (7'b0010011 << (i - 4));
    end
    return prod[3:0];
  endfunction

  assign load    = !m_valid || m_ready;
  assign s_ready = (state == ST_DATA) && load;
  assign fb      = s_data ^ p1;

`ifdef SQUID_ENC_ERR_INJ_EN
  assign inj_xor = inj_en ? inj_mask : 4'h0;
`else
  assign inj_xor = 4'h0;
`endif

  // Parity LFSR always runs on the clean input; only the emitted symbol sees injection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_DATA;
      cnt         <= '0;
      p1          <= 4'h0;
      p0          <= 4'h0;
      m_valid     <= 1'b0;
      m_data      <= 4'h0;
      m_is_parity <= 1'b0;
      m_last      <= 1'b0;
    end else if (load) begin
      case (state)
        ST_DATA: begin
          if (s_valid) begin
            m_valid     <= 1'b1;
            m_data      <= s_data ^ inj_xor;
            m_is_parity <= 1'b0;
            m_last      <= 1'b0;
            p1          <= p0 ^ gfmul(fb, 4'h3);
            p0          <= gfmul(fb, 4'h2);
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= ST_PAR1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            m_valid <= 1'b0;
          end
        end
        ST_PAR1: begin
          m_valid     <= 1'b1;
          m_data      <= p1 ^ inj_xor;
          m_is_parity <= 1'b1;
          m_last      <= 1'b0;
          state       <= ST_PAR0;
        end
        ST_PAR0: begin
          m_valid     <= 1'b1;
          m_data      <= p0 ^ inj_xor;
          m_is_parity <= 1'b1;
          m_last      <= 1'b1;
          p1          <= 4'h0;
          p0          <= 4'h0;
          state       <= ST_DATA;
        end
        default: begin
          m_valid <= 1'b0;
          state   <= ST_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_squid_rs_encoder.sv
// Self-checking bench for squid_rs_encoder: scoreboard of expected symbols plus a syndrome check per codeword.
// Define SQUID_ENC_ERR_INJ_EN to also exercise output error injection.
module tb_squid_rs_encoder;

  typedef struct packed {
    logic [3:0] data;
    logic       par;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       m_is_parity;
  logic       m_last;
`ifdef SQUID_ENC_ERR_INJ_EN
  logic       inj_en;
  logic [3:0] inj_mask;
`endif

  int         checks;
  int         errors;
  bit         stall_mode;
  bit         inj_cw;
  exp_t       exp_q[$];
  logic [3:0] cw[$];
  logic [3:0] gf_exp[15];
  int         gf_log[16];

  squid_rs_encoder #(.DATA_SYMS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_is_parity(m_is_parity),
    .m_last(m_last)
`ifdef SQUID_ENC_ERR_INJ_EN
    ,
    .inj_en(inj_en),
    .inj_mask(inj_mask)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream readiness: always ready, or randomly stalling about a quarter of the time.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // GF(16) multiply through log/antilog tables.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return gf_exp[(gf_log[a] + gf_log[b]) % 15];
  endfunction

  // Remainder of d(x)*x^2 divided by g(x), by polynomial long division.
  function automatic logic [7:0] modelParity();
    logic [3:0] m[$];
    logic [3:0] c;
    int n;
    m = cw;
    n = cw.size();
    m.push_back(4'h0);
    m.push_back(4'h0);
    for (int i = 0; i < n; i++) begin
      c = m[i];
      m[i + 1] = m[i + 1] ^ gmul(c, 4'h3);
      m[i + 2] = m[i + 2] ^ gmul(c, 4'h2);
    end
    return {m[n], m[n + 1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Offer one data symbol until accepted, then record its expected output.
  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] emask);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
`ifdef SQUID_ENC_ERR_INJ_EN
    inj_en   = (emask != 4'h0);
    inj_mask = emask;
`endif
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
`ifdef SQUID_ENC_ERR_INJ_EN
    inj_en   = 1'b0;
    inj_mask = 4'h0;
`endif
    checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
    if (acc) begin
      exp_q.push_back('{data: d ^ emask, par: 1'b0, last: 1'b0});
      cw.push_back(d);
    end
  endtask

  task automatic finishCodeword(input bit use_const, input logic [3:0] c1, input logic [3:0] c0);
    logic [7:0] p;
    p = use_const ? {c1, c0} : modelParity();
    exp_q.push_back('{data: p[7:4], par: 1'b1, last: 1'b0});
    exp_q.push_back('{data: p[3:0], par: 1'b1, last: 1'b1});
    cw.delete();
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stall hold and syndromes.
  logic [3:0] syn1;
  logic [3:0] syna;
  bit         stalled;
  logic [6:0] prev_out;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      syn1    = 4'h0;
      syna    = 4'h0;
      stalled = 1'b0;
    end else begin
      if (stalled) checkOutput("stall_hold", {m_valid, m_data, m_is_parity, m_last}, prev_out);
      if (m_valid && !m_ready) checkOutput("s_ready_stall", s_ready, 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("m_data", m_data, e.data);
          checkOutput("m_is_parity", m_is_parity, e.par);
          checkOutput("m_last", m_last, e.last);
        end
        syn1 = syn1 ^ m_data;
        syna = gmul(syna, 4'h2) ^ m_data;
        if (m_last) begin
          if (!inj_cw) begin
            checkOutput("syndrome_c1", syn1, 32'd0);
            checkOutput("syndrome_calpha", syna, 32'd0);
          end
          syn1 = 4'h0;
          syna = 4'h0;
        end
      end
      stalled  = m_valid && !m_ready;
      prev_out = {m_valid, m_data, m_is_parity, m_last};
    end
  end

  initial begin
    logic [3:0] v;
    checks     = 0;
    errors     = 0;
    stall_mode = 1'b0;
    inj_cw     = 1'b0;
    v = 4'h1;
    for (int i = 0; i < 15; i++) begin
      gf_exp[i] = v;
      gf_log[v] = i;
      v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
    end
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 4'h0;
`ifdef SQUID_ENC_ERR_INJ_EN
    inj_en   = 1'b0;
    inj_mask = 4'h0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", m_valid, 32'd0);
    checkOutput("reset_m_data", m_data, 32'd0);
    checkOutput("reset_m_is_parity", m_is_parity, 32'd0);
    checkOutput("reset_m_last", m_last, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_s_ready", s_ready, 32'd1);

    // All-zero codeword gives zero parity.
    for (int i = 0; i < 8; i++) applyStimulus(4'h0, 4'h0);
    finishCodeword(1'b1, 4'h0, 4'h0);

    // s_ready drops for the two parity cycles, then the next codeword starts with no bubble.
    s_valid = 1'b1;
    s_data  = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("s_ready_parity_seq", s_ready, (k == 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    exp_q.push_back('{data: 4'h0, par: 1'b0, last: 1'b0});
    cw.push_back(4'h0);
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, 4'h0);
    applyStimulus(4'h1, 4'h0);
    finishCodeword(1'b1, 4'h3, 4'h2);

    // Data 0,...,0,1,0.
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, 4'h0);
    applyStimulus(4'h1, 4'h0);
    applyStimulus(4'h0, 4'h0);
    finishCodeword(1'b1, 4'h7, 4'h6);
    waitDrain();

    // Random data with random downstream stalls.
    stall_mode = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) applyStimulus(4'($urandom_range(0, 15)), 4'h0);
      finishCodeword(1'b0, 4'h0, 4'h0);
    end
    waitDrain();
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset after four accepted symbols discards the partial codeword.
    applyStimulus(4'h9, 4'h0);
    checkOutput("latency_m_valid", m_valid, 32'd1);
    checkOutput("latency_m_data", m_data, 32'h9);
    applyStimulus(4'hA, 4'h0);
    applyStimulus(4'hB, 4'h0);
    applyStimulus(4'hC, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_m_valid", m_valid, 32'd0);
    checkOutput("midreset_m_data", m_data, 32'd0);
    checkOutput("midreset_m_is_parity", m_is_parity, 32'd0);
    checkOutput("midreset_m_last", m_last, 32'd0);
    cw.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_s_ready", s_ready, 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(4'h0, 4'h0);
    applyStimulus(4'h1, 4'h0);
    finishCodeword(1'b1, 4'h3, 4'h2);
    waitDrain();

`ifdef SQUID_ENC_ERR_INJ_EN
    // Injection corrupts data symbol 3 only; parity follows the clean data.
    inj_cw = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(4'(i + 1), (i == 3) ? 4'h5 : 4'h0);
    finishCodeword(1'b0, 4'h0, 4'h0);
    waitDrain();
    inj_cw = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
